// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and constants for the multiply/divide controller
package muldiv_pkg;

    localparam int MD_STEPS = 32;
    localparam int MD_CNT_W = 6;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } md_state_t;

    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// rtl/muldiv_core.sv - iterative shift-add multiplier / restoring divider datapath with sign fix-up
module muldiv_core
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        step,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res
);

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;

    logic [31:0] opnd;
    logic [63:0] acc;
    logic [31:0] a_raw;
    logic        is_div, neg_lo, neg_hi, div_zero;

    logic [32:0] mul_sum;
    logic [63:0] mul_nxt;
    logic [32:0] rem_sh;
    logic [33:0] diff;
    logic [63:0] div_nxt;
    logic [63:0] prod;
    logic [31:0] quo, rem;

    assign a_neg = md_is_signed(op) & src_a[31];
    assign b_neg = md_is_signed(op) & src_b[31];
    assign a_mag = a_neg ? -src_a : src_a;
    assign b_mag = b_neg ? -src_b : src_b;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            opnd     <= '0;
            acc      <= '0;
            a_raw    <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
        end else if (load) begin
            // Multiply keeps the multiplier in acc[31:0]; divide keeps the dividend there.
            opnd     <= md_is_div(op) ? b_mag : a_mag;
            acc      <= {32'd0, md_is_div(op) ? a_mag : b_mag};
            a_raw    <= src_a;
            is_div   <= md_is_div(op);
            neg_lo   <= a_neg ^ b_neg;
            neg_hi   <= md_is_div(op) ? a_neg : (a_neg ^ b_neg);
            div_zero <= md_is_div(op) && (src_b == 32'd0);
        end else if (step) begin
            acc <= is_div ? div_nxt : mul_nxt;
        end
    end

    assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    assign mul_nxt = {mul_sum, acc[31:1]};

    // A shifted remainder above 32 bits always exceeds the divisor, so bit 32 drops safely on borrow.
    assign rem_sh  = acc[63:31];
    assign diff    = {1'b0, rem_sh} - {2'b00, opnd};
    assign div_nxt = diff[33] ? {rem_sh[31:0], acc[30:0], 1'b0}
                              : {diff[31:0],   acc[30:0], 1'b1};

    // Results are taken from the step in flight so HI/LO can load on the final step edge.
    assign prod = neg_lo ? -mul_nxt : mul_nxt;
    assign quo  = neg_lo ? -div_nxt[31:0]  : div_nxt[31:0];
    assign rem  = neg_hi ? -div_nxt[63:32] : div_nxt[63:32];

    always_comb begin
        hi_res = prod[63:32];
        lo_res = prod[31:0];
        if (is_div) begin
            if (div_zero) begin
                hi_res = a_raw;
                lo_res = 32'hFFFF_FFFF;
            end else begin
                hi_res = rem;
                lo_res = quo;
            end
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - mul/div sequencer, HI/LO owner and stall source; MULDIV_FAST_MUL_EN selects single-cycle multiply
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int STEPS = MD_STEPS
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    input  logic        hilo_we,
    input  logic        hilo_wsel,
    input  logic [31:0] hilo_wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stallreq,
    output logic        busy,
    output logic        done
);

    localparam logic [MD_CNT_W-1:0] CNT_LAST = MD_CNT_W'(STEPS - 1);

    md_state_t             state, state_nxt;
    logic [MD_CNT_W-1:0]   cnt;
    logic                  start_go, last_step, fast_go;
    logic                  res_we, wr_en;
    logic [31:0]           core_hi, core_lo;
    logic [31:0]           res_hi, res_lo;

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] ext_a, ext_b, fast_prod;

    // Low 64 bits of a 64x64 product of extended operands serve both signed and unsigned forms.
    assign ext_a     = {{32{md_is_signed(op) & src_a[31]}}, src_a};
    assign ext_b     = {{32{md_is_signed(op) & src_b[31]}}, src_b};
    assign fast_prod = ext_a * ext_b;
    assign fast_go   = ~md_is_div(op);
    assign res_hi    = (start_go && fast_go) ? fast_prod[63:32] : core_hi;
    assign res_lo    = (start_go && fast_go) ? fast_prod[31:0]  : core_lo;
`else
    assign fast_go = 1'b0;
    assign res_hi  = core_hi;
    assign res_lo  = core_lo;
`endif

    assign start_go  = (state == ST_IDLE) && start && !cancel;
    assign last_step = (state == ST_BUSY) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_go) state_nxt = fast_go ? ST_DONE : ST_BUSY;
            ST_BUSY: if (last_step) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (cancel) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (start_go) begin
            cnt <= '0;
        end else if (state == ST_BUSY) begin
            cnt <= cnt + MD_CNT_W'(1);
        end
    end

    muldiv_core u_core (
        .clk    (clk),
        .resetn (resetn),
        .load   (start_go),
        .step   (state == ST_BUSY),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .hi_res (core_hi),
        .lo_res (core_lo)
    );

    assign res_we = (last_step && !cancel) || (start_go && fast_go);
    // A flush also swallows an MTHI/MTLO issued in the same cycle.
    assign wr_en  = hilo_we && !cancel &&
                    (((state == ST_IDLE) && !start) || (state == ST_DONE));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi <= '0;
            lo <= '0;
        end else if (res_we) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if (wr_en) begin
            if (hilo_wsel) hi <= hilo_wdata;
            else           lo <= hilo_wdata;
        end
    end

    assign stallreq = (((state == ST_IDLE) && start) || (state == ST_BUSY)) && !cancel;
    assign busy     = (state == ST_BUSY);
    assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - randomized self-checking bench for muldiv_ctrl against an arithmetic model
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        cancel;
    logic        hilo_we, hilo_wsel;
    logic [31:0] hilo_wdata;
    logic [31:0] hi, lo;
    logic        stallreq, busy, done;

    int vectors = 0;
    int errors  = 0;
    logic [31:0] ref_hi, ref_lo;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    always #5 clk = ~clk;

    muldiv_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .cancel     (cancel),
        .hilo_we    (hilo_we),
        .hilo_wsel  (hilo_wsel),
        .hilo_wdata (hilo_wdata),
        .hi         (hi),
        .lo         (lo),
        .stallreq   (stallreq),
        .busy       (busy),
        .done       (done)
    );

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] ua, ub;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (o[1]) begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (o == 2'b10) return {32'(sa % sb), 32'(sa / sb)};
            return {a % b, a / b};
        end
        if (o == 2'b00) return 64'(sa * sb);
        return ua * ub;
    endfunction

    function automatic int exp_stall(input logic [1:0] o);
        return (FAST && !o[1]) ? 1 : 33;
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit noise, output int stalls, output int busy_cyc,
                          output int early_done, output logic done_end,
                          output logic [31:0] h, output logic [31:0] l);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        stalls = 0; busy_cyc = 0; early_done = 0;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (!stallreq) break;
            stalls++;
            if (busy) busy_cyc++;
            if (done) early_done++;
            @(negedge clk);
            if (noise) begin
                hilo_we = 1'b1; hilo_wsel = 1'($urandom); hilo_wdata = $urandom;
            end
        end
        hilo_we = 1'b0;
        done_end = done;
        h = hi;
        l = lo;
        start = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        cancel = 1'b0; hilo_we = 1'b0; hilo_wsel = 1'b0; hilo_wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        vectors++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
        vectors++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
        vectors++; if ({busy, done, stallreq} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy, done, stallreq}); end
        start = 1'b1; #1;
        vectors++; if (stallreq !== 1'b1) begin errors++; $display("FAIL reset_stall_start got %b want 1", stallreq); end
        start = 1'b0;
        @(negedge clk); resetn = 1'b1;
        ref_hi = 32'd0; ref_lo = 32'd0;
    endtask

    task automatic test_directed;
        logic [1:0]  ops [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        logic [31:0] as  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
        logic [31:0] bs  [4] = '{32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF};
        int st, bc, ed; logic de; logic [31:0] h, l; logic [63:0] e;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], 1'b0, st, bc, ed, de, h, l);
            e = model(ops[i], as[i], bs[i]);
            vectors++; if (h !== e[63:32]) begin errors++; $display("FAIL dir%0d_hi got %h want %h", i, h, e[63:32]); end
            vectors++; if (l !== e[31:0]) begin errors++; $display("FAIL dir%0d_lo got %h want %h", i, l, e[31:0]); end
            vectors++; if (st !== exp_stall(ops[i])) begin errors++; $display("FAIL dir%0d_stall got %0d want %0d", i, st, exp_stall(ops[i])); end
            vectors++; if (bc !== exp_stall(ops[i]) - 1) begin errors++; $display("FAIL dir%0d_busy got %0d want %0d", i, bc, exp_stall(ops[i]) - 1); end
            vectors++; if (de !== 1'b1 || ed !== 0) begin errors++; $display("FAIL dir%0d_done got end=%b early=%0d want end=1 early=0", i, de, ed); end
            ref_hi = e[63:32]; ref_lo = e[31:0];
        end
    endtask

    task automatic test_cancel;
        logic [31:0] w;
        @(negedge clk);
        start = 1'b1; op = 2'b10; src_a = 32'd100; src_b = 32'd3;
        repeat (10) @(negedge clk);
        cancel = 1'b1; #1;
        vectors++; if (stallreq !== 1'b0) begin errors++; $display("FAIL cancel_stall got %b want 0", stallreq); end
        @(negedge clk);
        cancel = 1'b0; start = 1'b0; #1;
        vectors++; if ({busy, done, stallreq} !== 3'b000) begin errors++; $display("FAIL cancel_idle got %b want 000", {busy, done, stallreq}); end
        vectors++; if ({hi, lo} !== {ref_hi, ref_lo}) begin errors++; $display("FAIL cancel_hilo got %h want %h", {hi, lo}, {ref_hi, ref_lo}); end
        hilo_we = 1'b1; hilo_wsel = 1'b0; hilo_wdata = 32'h1234;
        @(negedge clk);
        hilo_we = 1'b0; #1;
        ref_lo = 32'h1234;
        vectors++; if (lo !== ref_lo) begin errors++; $display("FAIL mtlo got %h want %h", lo, ref_lo); end
        w = $urandom;
        hilo_we = 1'b1; hilo_wsel = 1'b1; hilo_wdata = w;
        @(negedge clk);
        hilo_we = 1'b0; #1;
        ref_hi = w;
        vectors++; if ({hi, lo} !== {ref_hi, ref_lo}) begin errors++; $display("FAIL mthi got %h want %h", {hi, lo}, {ref_hi, ref_lo}); end
        start = 1'b1; op = 2'b11; src_a = 32'd9; src_b = 32'd2; cancel = 1'b1;
        hilo_we = 1'b1; hilo_wsel = 1'b0; hilo_wdata = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0; hilo_we = 1'b0; #1;
        vectors++; if ({busy, lo} !== {1'b0, ref_lo}) begin errors++; $display("FAIL cancel_start got busy=%b lo=%h want busy=0 lo=%h", busy, lo, ref_lo); end
    endtask

    task automatic test_reset_mid;
        int st, bc, ed; logic de; logic [31:0] h, l; logic [63:0] e;
        @(negedge clk);
        start = 1'b1; op = 2'b00; src_a = $urandom; src_b = $urandom;
        repeat (20) @(negedge clk);
        resetn = 1'b0; #1;
        vectors++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL rstmid_hilo got %h want 0", {hi, lo}); end
        vectors++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rstmid_flags got %b want 00", {busy, done}); end
        start = 1'b0; #1;
        vectors++; if (stallreq !== 1'b0) begin errors++; $display("FAIL rstmid_stall got %b want 0", stallreq); end
        @(negedge clk); resetn = 1'b1;
        run_op(2'b11, 32'd10, 32'd3, 1'b0, st, bc, ed, de, h, l);
        e = model(2'b11, 32'd10, 32'd3);
        vectors++; if ({h, l} !== e) begin errors++; $display("FAIL rstmid_divu got %h want %h", {h, l}, e); end
        ref_hi = e[63:32]; ref_lo = e[31:0];
    endtask

    task automatic test_back_to_back;
        int st, bc, ed; logic de; logic [31:0] h, l, a, b; logic [1:0] o; logic [63:0] e; bit nz;
        for (int i = 0; i < 30; i++) begin
            o  = 2'($urandom);
            a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom);
            nz = 1'($urandom);
            run_op(o, a, b, nz, st, bc, ed, de, h, l);
            e = model(o, a, b);
            vectors++; if ({h, l} !== e) begin errors++; $display("FAIL rnd%0d op=%0d a=%h b=%h got %h want %h", i, o, a, b, {h, l}, e); end
            vectors++; if (st !== exp_stall(o) || de !== 1'b1 || ed !== 0) begin
                errors++; $display("FAIL rnd%0d_timing got stall=%0d done=%b early=%0d want stall=%0d done=1 early=0", i, st, de, ed, exp_stall(o));
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_cancel;
        test_reset_mid;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide controller and HI/LO register owner for the 5-stage MIPS pipeline. It sits beside EX and accepts MULT/MULTU/DIV/DIVU issued from EX. It sequences an iterative shift-add multiplier and a restoring divider over 32 steps, and holds the pipeline via `stallreq` until the result is committed to HI/LO. It also services MTHI/MTLO writes and provides HI/LO read values to ID for MFHI/MFLO.

## Interface
Parameters:
- `STEPS`, 32: iteration count; equals operand width, not intended to change.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  pipeline clock
- `resetn`  in  1  asynchronous active-low reset
- `start`  in  1  EX holds a mul/div instruction; held high by the pipeline while stalled
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`
- `src_a`  in  32  rs value (multiplicand / dividend)
- `src_b`  in  32  rt value (multiplier / divisor)
- `cancel`  in  1  flush; aborts any operation in flight
- `hilo_we`  in  1  MTHI/MTLO write from EX
- `hilo_wsel`  in  1  1 = HI, 0 = LO
- `hilo_wdata`  in  32  write data
- `hi`  out  32  HI register
- `lo`  out  32  LO register
- `stallreq`  out  1  stall request to the stall controller (combinational)
- `busy`  out  1  state is BUSY
- `done`  out  1  one-cycle pulse, state is DONE

## Operation
- FSM states: IDLE, BUSY, DONE. The step counter is 6 bits wide.
- IDLE with `start`=1 and `cancel`=0:
  - Latch |src_a| and |src_b|. Magnitudes apply to signed ops only; unsigned ops latch the raw values.
  - Latch the result sign flags and the op.
  - Clear the counter and go to BUSY.
- BUSY:
  - Perform one step per cycle.
  - Multiply: 64-bit product accumulates; if multiplier LSB is set, add the multiplicand into the upper half, then shift right.
  - Divide: 64-bit remainder:quotient register; shift left, trial-subtract the divisor, set the quotient bit on no borrow.
  - When the counter reaches STEPS-1, apply the sign fix-up, load HI/LO on that edge, and go to DONE.
- Sign rules:
  - Product is negated if signs differ.
  - Quotient is negated if signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives LO=0x80000000, HI=0.
- Divide by zero, any op: LO=0xFFFFFFFF, HI=src_a as latched (original value, not magnitude). No exception is raised.
- DONE: lasts exactly one cycle, then goes to IDLE. `start` is ignored in DONE because the instruction is leaving EX.
- `stallreq` = (IDLE & `start` & !`cancel`) | BUSY. It is low in DONE, so the stalled instruction advances.
- `cancel`:
  - In any state, the next state is IDLE, HI/LO are unchanged, and `stallreq` is forced low combinationally.
  - `cancel` takes priority over `start` and over the final load.
- HI/LO write port:
  - Applied at the clock edge when in IDLE or DONE.
  - Ignored in BUSY.
  - If `start` and `hilo_we` are both asserted in IDLE, the op starts and the write is dropped. The decoder never issues both.
- `resetn` low, including mid-operation: immediate return to IDLE. HI=0, LO=0, counter=0, `busy`=0, `done`=0; `stallreq`=0 unless `start` is high.

## Timing
- Start cycle is T0 (IDLE, `stallreq`=1). BUSY occupies T1..T32. HI/LO are updated at the edge ending T32. DONE is T33, with `stallreq`=0.
- Stall length is 33 cycles. A result is readable by MFHI/MFLO in ID from T33 onward.
- HI/LO outputs are registered. Forwarding of an in-flight result is not required, since the pipeline is frozen.
- Back-to-back ops: the second op's start is sampled in the cycle after DONE (IDLE). There is no bubble beyond DONE.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MULT/MULTU use a single-cycle signed/unsigned 32x32 multiply.
  - In IDLE, start loads HI/LO at the end of T0 and goes directly to DONE. The stall is 1 cycle.
  - Divide is unaffected.
- `MULDIV_FAST_MUL_EN` undefined: all four ops use the 32-step iterative path with a 33-cycle stall.

## Structure
- Shared package `muldiv_pkg` holds:
  - op encodings (`MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`)
  - FSM state encodings
  - `MD_STEPS`
  - the 6-bit counter width
- `muldiv_ctrl` holds the FSM, counter, HI/LO registers, write port and stall logic.
- One sub-module, `muldiv_core`, holds the operand/accumulator registers, the per-step add/subtract datapath and the sign fix-up. It takes `load`, `step`, `op` and produces `{hi_res, lo_res}`.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. `stallreq` high exactly 33 cycles; `done` pulses at T33.
- DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU 7 / 0 → LO=0xFFFFFFFF, HI=0x00000007.
- MULT 0x80000000 × 0xFFFFFFFF → HI=0x00000000, LO=0x80000000. With `MULDIV_FAST_MUL_EN` the same result appears after a 1-cycle stall.
- `cancel` asserted at T10 of DIV 100/3 → IDLE next cycle, `stallreq` low in the same cycle, HI/LO keep prior values. Then MTLO 0x1234 in IDLE → LO=0x1234.
- `resetn` pulsed low at T20 of MULT → HI=LO=0, `busy`=0 immediately. A new DIVU 10/3 afterwards gives LO=3, HI=1.
